// File: rtl/intersection_traffic_model.sv
// Intersection traffic model: five lane queues fed by arrival pulses and drained by the
// controller's green lights, plus sticky checkers for unsafe light behaviour.
package light_package;
  typedef enum logic [1:0] {red = 2'd0, yellow = 2'd1, green = 2'd2} colors;
endpackage

module intersection_traffic_model #(
  parameter int QMAX = 15,
  parameter int QW   = 4,
  parameter int YMIN = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  light_package::colors e_str_light,
  input  light_package::colors w_str_light,
  input  light_package::colors e_left_light,
  input  light_package::colors w_left_light,
  input  light_package::colors ns_light,
  input  logic [4:0]           arrive,
  output logic                 e_str_sensor,
  output logic                 w_str_sensor,
  output logic                 e_left_sensor,
  output logic                 w_left_sensor,
  output logic                 ns_sensor,
  output logic [QW-1:0]        q_e_str,
  output logic [QW-1:0]        q_w_str,
  output logic [QW-1:0]        q_e_left,
  output logic [QW-1:0]        q_w_left,
  output logic [QW-1:0]        q_ns,
  output logic [15:0]          departed,
  output logic                 conflict_err,
  output logic                 seq_err,
  output logic                 gap_err,
  output logic                 overflow_err
);
  import light_package::*;

  localparam int NL = 5;
  localparam int YW = (YMIN < 1) ? 1 : $clog2(YMIN + 1);

  typedef enum logic [1:0] {RED, GRN, YEL} phase_e;

  colors         lights      [NL];
  colors         prevLight_q [NL];
  logic [QW-1:0] queue_q     [NL];
  logic [QW-1:0] queue_d     [NL];
  phase_e        phase_q     [NL];
  phase_e        phase_d     [NL];
  logic [YW-1:0] ycnt_q      [NL];
  logic [YW-1:0] ycnt_d      [NL];
  logic [15:0]   departed_q, departed_d;
  logic          conflictErr_q, seqErr_q, gapErr_q, overflowErr_q;
  logic          conflictHit, seqHit, gapHit, overflowHit;
  logic          anyPrevYellow, anyNewGreen;
  logic [NL-1:0] depart, active;
  logic [2:0]    depCount;

  // Lane index order matches the arrive bit order
  assign lights[0] = e_str_light;
  assign lights[1] = w_str_light;
  assign lights[2] = e_left_light;
  assign lights[3] = w_left_light;
  assign lights[4] = ns_light;

  always_comb begin
    depart        = '0;
    active        = '0;
    depCount      = '0;
    overflowHit   = 1'b0;
    seqHit        = 1'b0;
    anyPrevYellow = 1'b0;
    anyNewGreen   = 1'b0;
    for (int i = 0; i < NL; i++) begin
      queue_d[i] = queue_q[i];
      phase_d[i] = phase_q[i];
      ycnt_d[i]  = ycnt_q[i];
      active[i]  = (lights[i] != red);
      depart[i]  = (lights[i] == green) && (queue_q[i] != '0);
      depCount   = depCount + {2'b00, depart[i]};
      if (arrive[i] && !depart[i]) begin
        if (queue_q[i] == QW'(QMAX)) overflowHit = 1'b1;
        else                         queue_d[i]  = queue_q[i] + QW'(1);
      end else if (depart[i] && !arrive[i]) begin
        queue_d[i] = queue_q[i] - QW'(1);
      end
      if (prevLight_q[i] == yellow) anyPrevYellow = 1'b1;
      if (prevLight_q[i] == red && lights[i] == green) anyNewGreen = 1'b1;
      // ycnt counts the yellow cycles seen so far in the current yellow run
      case (phase_q[i])
        RED: begin
          if (lights[i] == green) begin
            phase_d[i] = GRN;
          end else if (lights[i] == yellow) begin
            phase_d[i] = YEL;
            ycnt_d[i]  = YW'(1);
            seqHit     = 1'b1;
          end
        end
        GRN: begin
          if (lights[i] == yellow) begin
            phase_d[i] = YEL;
            ycnt_d[i]  = YW'(1);
          end else if (lights[i] == red) begin
            phase_d[i] = RED;
            seqHit     = 1'b1;
          end
        end
        YEL: begin
          if (lights[i] == yellow) begin
            if (ycnt_q[i] < YW'(YMIN)) ycnt_d[i] = ycnt_q[i] + YW'(1);
          end else if (lights[i] == red) begin
            phase_d[i] = RED;
            ycnt_d[i]  = '0;
            if (ycnt_q[i] < YW'(YMIN)) seqHit = 1'b1;
          end else begin
            phase_d[i] = GRN;
            ycnt_d[i]  = '0;
            seqHit     = 1'b1;
          end
        end
        default: begin
          phase_d[i] = RED;
          ycnt_d[i]  = '0;
        end
      endcase
    end
  end

  assign conflictHit = (active[0] & active[3]) | (active[1] & active[2]) |
                       (active[4] & (|active[3:0]));
  assign gapHit      = anyPrevYellow & anyNewGreen;
  assign departed_d  = departed_q + {13'b0, depCount};

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NL; i++) begin
        queue_q[i]     <= '0;
        prevLight_q[i] <= red;
        phase_q[i]     <= RED;
        ycnt_q[i]      <= '0;
      end
      departed_q    <= '0;
      conflictErr_q <= 1'b0;
      seqErr_q      <= 1'b0;
      gapErr_q      <= 1'b0;
      overflowErr_q <= 1'b0;
    end else begin
      for (int i = 0; i < NL; i++) begin
        queue_q[i]     <= queue_d[i];
        prevLight_q[i] <= lights[i];
        phase_q[i]     <= phase_d[i];
        ycnt_q[i]      <= ycnt_d[i];
      end
      departed_q    <= departed_d;
      conflictErr_q <= conflictErr_q | conflictHit;
      seqErr_q      <= seqErr_q | seqHit;
      gapErr_q      <= gapErr_q | gapHit;
      overflowErr_q <= overflowErr_q | overflowHit;
    end
  end

  assign q_e_str       = queue_q[0];
  assign q_w_str       = queue_q[1];
  assign q_e_left      = queue_q[2];
  assign q_w_left      = queue_q[3];
  assign q_ns          = queue_q[4];
  assign e_str_sensor  = (queue_q[0] != '0);
  assign w_str_sensor  = (queue_q[1] != '0);
  assign e_left_sensor = (queue_q[2] != '0);
  assign w_left_sensor = (queue_q[3] != '0);
  assign ns_sensor     = (queue_q[4] != '0);
  assign departed      = departed_q;
  assign conflict_err  = conflictErr_q;
  assign seq_err       = seqErr_q;
  assign gap_err       = gapErr_q;
  assign overflow_err  = overflowErr_q;

endmodule
